pwm_table_sequencer: RTL and testbench

//  Controller for the PWM signal-table memory. Sequences playback reads at the

---
 rtl/pwm_table_sequencer_pkg.sv | 19 +
 rtl/pwm_table_sequencer_tick_gen.sv | 44 ++++
 rtl/pwm_table_sequencer.sv | 145 ++++++++++++++
 tb/tb_pwm_table_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_table_sequencer_pkg.sv
// Shared definitions for the PWM blocks: playback FSM state encoding, default
// sample/address widths and a counter-width helper.
package pwm_table_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StDone = 2'd2
  } pwm_state_e;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefAddrWidth = 7;

  // Width of a counter that runs 0..div-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/pwm_table_sequencer_tick_gen.sv
// Clock-enable generator: a counter that runs 0..TICK_DIV-1 while enabled.
// Ports:
//   ClkOsc  system clock
//   Rst     asynchronous reset, active low
//   En      advance the counter this cycle
//   Clr     force the counter to 0 (wins over En)
//   Tick    high while the counter is 0
module pwm_table_sequencer_tick_gen
  import pwm_table_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic ClkOsc,
  input  logic Rst,
  input  logic En,
  input  logic Clr,
  output logic Tick
);

  localparam int unsigned CntW = cnt_width(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (Clr) begin
      cnt_d = '0;
    end else if (En) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge ClkOsc or negedge Rst) begin
    if (!Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Tick = (cnt_q == '0);

endmodule

// File: rtl/pwm_table_sequencer.sv
// Playback sequencer and host-write arbiter for the PWM signal-table RAM.
// Issues one table read every TICK_DIV cycles while playing (one-shot or loop)
// and slots host writes onto the same single RAM port, reads first.
// Ports:
//   ClkOsc, Rst                  clock, asynchronous active-low reset
//   Start, Stop                  1-cycle control pulses (Stop wins)
//   Loop                         wrap at end of table when high
//   HostWrReq/Addr/Data          host write request (held until HostWrAck)
//   HostWrAck, HostErr           request consumed / address out of range
//   MemAddr, MemWR, MemRdEn,
//   MemDataIn                    RAM port
//   Playing, Done                status
module pwm_table_sequencer
  import pwm_table_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned TABLE_DEPTH = 100,
  parameter int unsigned TICK_DIV    = 50000
) (
  input  logic                  ClkOsc,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic                  Stop,
  input  logic                  Loop,
  input  logic                  HostWrReq,
  input  logic [ADDR_WIDTH-1:0] HostAddr,
  input  logic [DATA_WIDTH-1:0] HostData,
  output logic                  HostWrAck,
  output logic                  HostErr,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic                  MemWR,
  output logic                  MemRdEn,
  output logic [DATA_WIDTH-1:0] MemDataIn,
  output logic                  Playing,
  output logic                  Done
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(TABLE_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(TABLE_DEPTH);

  pwm_state_e state_q;
  logic [ADDR_WIDTH-1:0] play_addr_q;  // address of the next read
  logic [ADDR_WIDTH-1:0] last_addr_q;  // address of the most recent read
  logic                  end_q;        // last read was the final table entry
  logic                  rd_q, wr_q, ack_q, err_q, done_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_q;

  logic tick, in_play, start_ok, go_done, play_read, read_due, run, clear;
  logic grant, addr_bad, wr_go;
  logic [ADDR_WIDTH-1:0] rd_addr, last_addr_d;

  // Outputs are registered, so every decision is made on the edge that opens
  // the cycle it affects. The tick counter is held at 0 outside playback, so
  // Tick marks "the next cycle is a sample slot".
  assign in_play   = (state_q == StPlay);
  assign start_ok  = Start && !Stop && !in_play;
  assign go_done   = in_play && tick && end_q && !Loop && !Stop;
  assign play_read = in_play && tick && !Stop && !go_done;
  assign read_due  = start_ok || play_read;
  assign run       = (in_play && !Stop && !go_done) || start_ok;
  assign clear     = Stop && (state_q != StIdle);
  assign rd_addr   = start_ok ? '0 : play_addr_q;

  // ack_q blocks a second grant for a request the host is still holding.
  assign grant    = HostWrReq && !ack_q && !read_due;
  assign addr_bad = ({1'b0, HostAddr} >= DepthExt);
  assign wr_go    = grant && !addr_bad;

  assign last_addr_d = clear ? '0 : (read_due ? rd_addr : last_addr_q);

  pwm_table_sequencer_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .ClkOsc(ClkOsc),
    .Rst   (Rst),
    .En    (run),
    .Clr   (!run),
    .Tick  (tick)
  );

  always_ff @(posedge ClkOsc or negedge Rst) begin
    if (!Rst) begin
      state_q     <= StIdle;
      play_addr_q <= '0;
      last_addr_q <= '0;
      end_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle:  if (start_ok) state_q <= StPlay;
        StPlay: begin
          if (Stop) state_q <= StIdle;
          else if (go_done) state_q <= StDone;
        end
        StDone: begin
          if (Stop) state_q <= StIdle;
          else if (Start) state_q <= StPlay;
        end
        default: state_q <= StIdle;
      endcase

      if (clear) begin
        play_addr_q <= '0;
        end_q       <= 1'b0;
      end else if (read_due) begin
        play_addr_q <= (rd_addr == LastAddr) ? '0 : rd_addr + ADDR_WIDTH'(1);
        end_q       <= (rd_addr == LastAddr);
      end

      last_addr_q <= last_addr_d;
      rd_q        <= read_due;
      wr_q        <= wr_go;
      ack_q       <= grant;
      err_q       <= grant && addr_bad;
      done_q      <= go_done;

      if (read_due) begin
        mem_addr_q <= rd_addr;
      end else if (wr_go) begin
        mem_addr_q <= HostAddr;
        mem_data_q <= HostData;
      end else begin
        mem_addr_q <= last_addr_d;
      end
    end
  end

  assign MemAddr   = mem_addr_q;
  assign MemWR     = wr_q;
  assign MemRdEn   = rd_q;
  assign MemDataIn = mem_data_q;
  assign HostWrAck = ack_q;
  assign HostErr   = err_q;
  assign Playing   = in_play;
  assign Done      = done_q;

endmodule

// File: tb/tb_pwm_table_sequencer.sv
module tb_pwm_table_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DIV = 4;

  logic          ClkOsc = 1'b0;
  logic          Rst = 1'b0;
  logic          Start = 1'b0, Stop = 1'b0, Loop = 1'b0;
  logic          HostWrReq = 1'b0;
  logic [AW-1:0] HostAddr = '0;
  logic [DW-1:0] HostData = '0;
  logic          HostWrAck, HostErr, MemWR, MemRdEn, Playing, Done;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemDataIn;

  pwm_table_sequencer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TABLE_DEPTH(DEPTH),
    .TICK_DIV   (DIV)
  ) dut (
    .ClkOsc   (ClkOsc),
    .Rst      (Rst),
    .Start    (Start),
    .Stop     (Stop),
    .Loop     (Loop),
    .HostWrReq(HostWrReq),
    .HostAddr (HostAddr),
    .HostData (HostData),
    .HostWrAck(HostWrAck),
    .HostErr  (HostErr),
    .MemAddr  (MemAddr),
    .MemWR    (MemWR),
    .MemRdEn  (MemRdEn),
    .MemDataIn(MemDataIn),
    .Playing  (Playing),
    .Done     (Done)
  );

  always #5 ClkOsc = ~ClkOsc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: playback as "one sample every DIV cycles, sample k reads
  // table entry k mod DEPTH"; RAM contents tracked as a plain array.
  int          m_state;  // 0 idle, 1 play, 2 done
  int          m_wait;   // edges left until the next sample slot
  int          m_count;  // samples read since the last start
  int          m_last;   // last play address
  logic [DW-1:0] model_ram[DEPTH];
  logic [DW-1:0] seen_ram[2**AW];
  bit          e_rd, e_wr, e_ack, e_err, e_done, e_play;
  int          e_addr;
  logic [DW-1:0] e_data;

  int cyc = 0;
  int base = 0;
  int rd_off[$];
  int rd_adr[$];
  int done_off[$];
  bit host_rand = 0;

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_count = 0; m_last = 0;
    e_rd = 0; e_wr = 0; e_ack = 0; e_err = 0; e_done = 0; e_play = 0;
    e_addr = 0; e_data = '0;
  endtask

  task automatic model_edge();
    bit rd, wr, er, dn, g;
    int ra;
    rd = 0; wr = 0; er = 0; dn = 0; ra = 0;
    if (Stop) begin
      if (m_state != 0) begin
        m_state = 0; m_count = 0; m_last = 0;
      end
    end else if (Start && m_state != 1) begin
      m_state = 1; rd = 1; ra = 0; m_count = 1; m_wait = DIV;
    end else if (m_state == 1) begin
      m_wait--;
      if (m_wait == 0) begin
        if (m_count % DEPTH == 0 && !Loop) begin
          m_state = 2; dn = 1;
        end else begin
          rd = 1; ra = m_count % DEPTH; m_count++; m_wait = DIV;
        end
      end
    end
    if (rd) m_last = ra;
    g = HostWrReq && !e_ack && !rd;
    if (g) begin
      if (int'(HostAddr) >= DEPTH) er = 1;
      else begin
        wr = 1;
        model_ram[HostAddr] = HostData;
        e_data = HostData;
      end
    end
    e_addr = rd ? ra : (wr ? int'(HostAddr) : m_last);
    e_rd = rd; e_wr = wr; e_ack = g; e_err = er; e_done = dn; e_play = (m_state == 1);
  endtask

  task automatic check_outputs();
    check_eq("rd_en", 32'(MemRdEn), 32'(e_rd));
    check_eq("mem_wr", 32'(MemWR), 32'(e_wr));
    check_eq("mem_addr", 32'(MemAddr), 32'(e_addr));
    check_eq("mem_data", 32'(MemDataIn), 32'(e_data));
    check_eq("wr_ack", 32'(HostWrAck), 32'(e_ack));
    check_eq("host_err", 32'(HostErr), 32'(e_err));
    check_eq("playing", 32'(Playing), 32'(e_play));
    check_eq("done", 32'(Done), 32'(e_done));
    check_eq("rd_wr_excl", 32'(MemRdEn & MemWR), 32'(0));
    if (MemWR) seen_ram[MemAddr] = MemDataIn;
    if (MemRdEn) begin
      rd_off.push_back(cyc - base);
      rd_adr.push_back(int'(MemAddr));
      if (e_rd) check_eq("rd_data", 32'(seen_ram[MemAddr]), 32'(model_ram[e_addr]));
    end
    if (Done) done_off.push_back(cyc - base);
  endtask

  task automatic host_policy();
    if (!host_rand) return;
    if (!HostWrReq || e_ack) begin
      if ($urandom_range(0, 3) == 0) begin
        HostWrReq = 1'b1;
        HostAddr  = AW'($urandom_range(0, 5));
        HostData  = DW'($urandom);
      end else begin
        HostWrReq = 1'b0;
      end
    end
  endtask

  // One clock cycle: apply inputs, predict, clock, check.
  task automatic tick(input logic st, input logic sp);
    Start = st;
    Stop  = sp;
    host_policy();
    model_edge();
    @(posedge ClkOsc);
    cyc++;
    @(negedge ClkOsc);
    check_outputs();
  endtask

  task automatic async_reset();
    #2 Rst = 1'b0;
    #1;
    check_eq("rst_rd_en", 32'(MemRdEn), 0);
    check_eq("rst_mem_wr", 32'(MemWR), 0);
    check_eq("rst_ack", 32'(HostWrAck), 0);
    check_eq("rst_err", 32'(HostErr), 0);
    check_eq("rst_addr", 32'(MemAddr), 0);
    check_eq("rst_data", 32'(MemDataIn), 0);
    check_eq("rst_playing", 32'(Playing), 0);
    check_eq("rst_done", 32'(Done), 0);
    model_reset();
    @(negedge ClkOsc);
    @(negedge ClkOsc);
    check_outputs();
    Rst = 1'b1;
  endtask

  initial begin
    bit found;
    for (int i = 0; i < DEPTH; i++) model_ram[i] = '0;
    for (int i = 0; i < 2**AW; i++) seen_ram[i] = '0;
    model_reset();
    repeat (2) @(negedge ClkOsc);
    check_outputs();
    Rst = 1'b1;

    // One-shot: Start at cycle 10, reads at +1,+5,+9,+13, Done at +17.
    while (cyc < 10) tick(0, 0);
    Loop = 1'b0;
    base = cyc;
    rd_off.delete(); rd_adr.delete(); done_off.delete();
    tick(1, 0);
    repeat (22) tick(0, 0);
    check_eq("oneshot_nreads", rd_off.size(), 4);
    for (int i = 0; i < 4 && i < rd_off.size(); i++) begin
      check_eq("oneshot_rd_cycle", rd_off[i], 1 + 4 * i);
      check_eq("oneshot_rd_addr", rd_adr[i], i);
    end
    check_eq("oneshot_ndone", done_off.size(), 1);
    if (done_off.size() > 0) check_eq("oneshot_done_cycle", done_off[0], 17);

    // Loop: ten samples wrap through the table, no Done.
    Loop = 1'b1;
    rd_adr.delete(); done_off.delete();
    tick(1, 0);
    repeat (40) tick(0, 0);
    check_eq("loop_nreads_ge10", 32'(rd_adr.size() >= 10), 1);
    for (int i = 0; i < 10 && i < rd_adr.size(); i++) check_eq("loop_addr", rd_adr[i], i % 4);
    check_eq("loop_no_done", done_off.size(), 0);
    tick(0, 1);
    check_eq("stop_playing", 32'(Playing), 0);
    tick(1, 0);
    check_eq("restart_addr", 32'(MemAddr), 0);
    check_eq("restart_rd", 32'(MemRdEn), 1);

    // Write colliding with a read slot is deferred by one cycle.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (MemRdEn) found = 1; else tick(0, 0);
    end
    check_eq("wait_read_slot", 32'(found), 1);
    HostWrReq = 1'b1; HostAddr = 3'd2; HostData = 8'hA5;
    tick(0, 0);
    check_eq("wr_after_read_wr", 32'(MemWR), 1);
    check_eq("wr_after_read_ack", 32'(HostWrAck), 1);
    check_eq("wr_after_read_addr", 32'(MemAddr), 2);
    HostWrReq = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(0, 0);
      if (MemRdEn && MemAddr == 3'd2) found = 1;
    end
    check_eq("readback_seen", 32'(found), 1);
    check_eq("readback_a5", 32'(seen_ram[2]), 32'h A5);

    // Out-of-range write.
    HostWrReq = 1'b1; HostAddr = 3'd4; HostData = 8'h3C;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(0, 0);
      if (HostWrAck) found = 1;
    end
    check_eq("oor_ack", 32'(found), 1);
    check_eq("oor_err", 32'(HostErr), 1);
    check_eq("oor_no_wr", 32'(MemWR), 0);
    HostWrReq = 1'b0;

    // Start+Stop together from IDLE, and Start during PLAY.
    tick(0, 1);
    tick(1, 1);
    check_eq("start_stop_idle", 32'(Playing), 0);
    tick(1, 0);
    repeat (6) tick(0, 0);
    tick(1, 0);
    repeat (10) tick(0, 0);

    // Randomized run with host traffic and mid-operation resets.
    host_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) Loop = ~Loop;
      if (i % 400 == 399) begin
        async_reset();
        tick(1, 0);
        check_eq("post_rst_addr", 32'(MemAddr), 0);
      end else begin
        tick(($urandom_range(0, 29) == 0), ($urandom_range(0, 59) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
